// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer
//   Control and compute stage that sits behind the sliding-window memory.
//   For every output window it walks K*K taps. Each tap follows the same pattern:
//   pulse step, wait for the read data, then multiply-accumulate image x weight
//   on every lane. When the window is finished it writes the saturated per-lane
//   result into the simple memory. All NUM_UNITS lanes run in lockstep under one FSM.
//
// Ports
//   clk                clock, all logic on rising edge
//   reset              synchronous, active-high
//   start              single-cycle request, only honoured while idle
//   kernel_dim         kernel side K (taps per window = K*K), latched on start
//   num_outputs        windows to compute, latched on start
//   out_addr_base      simple-memory address of window 0, latched on start
//   en, read_mem1/2    memory enables, equal to busy
//   step               one-cycle advance pulse to both window readers
//   mem1_data          per-lane image taps
//   mem2_data          per-lane weight taps
//   simple_write       one-cycle write strobe
//   simple_write_addr  per-lane write address (all lanes equal), held between writes
//   simple_write_data  per-lane saturated result, held between writes
//   busy               high in every state except idle
//   done               one-cycle completion pulse

module conv_mac_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4,
    parameter int NUM_UNITS    = 2,
    parameter int MEM_DEPTH    = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + 8,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(MEM_DEPTH),
    localparam int KW          = $clog2(IMAGE_WIDTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [KW-1:0]                   kernel_dim,
    input  logic [AW:0]                     num_outputs,
    input  logic [AW-1:0]                   out_addr_base,
    output logic                            en,
    output logic                            read_mem1,
    output logic                            read_mem2,
    output logic                            step,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] mem1_data,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] mem2_data,
    output logic                            simple_write,
    output logic [NUM_UNITS*AW-1:0]         simple_write_addr,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] simple_write_data,
    output logic                            busy,
    output logic                            done
);

    // K*K always fits in 2*KW bits because K <= 2^KW - 1.
    localparam int TW = 2 * KW;
    localparam int WW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [KW-1:0]  r_k;
    logic [AW:0]    r_num;
    logic [AW:0]    r_win;
    logic [AW-1:0]  r_addr;
    logic [TW-1:0]  r_tap;
    logic [WW-1:0]  r_wait;
    logic [NUM_UNITS*AW-1:0]         r_wr_addr_hold;
    logic [NUM_UNITS*DATA_WIDTH-1:0] r_wr_data_hold;

    logic [TW-1:0]  w_taps_total;
    logic [TW-1:0]  w_tap_inc;
    logic [AW:0]    w_win_inc;
    logic [AW-1:0]  w_base_mod;
    logic [AW-1:0]  w_addr_inc;
    logic           w_start_go;
    logic [NUM_UNITS*DATA_WIDTH-1:0] w_sat_bus;

    assign w_taps_total = TW'(r_k) * TW'(r_k);
    assign w_tap_inc    = r_tap + 1'b1;
    assign w_win_inc    = r_win + 1'b1;
    assign w_start_go   = (r_state == S_IDLE) && start;

    // The base can only exceed the depth when the depth is not a power of two.
    // In that case a single subtraction is enough to bring it into range.
    assign w_base_mod = ({1'b0, out_addr_base} >= (AW+1)'(MEM_DEPTH))
                      ? AW'({1'b0, out_addr_base} - (AW+1)'(MEM_DEPTH))
                      : out_addr_base;
    assign w_addr_inc = (r_addr == AW'(MEM_DEPTH - 1)) ? '0 : r_addr + 1'b1;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next state and strobes ----------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        step         = 1'b0;
        simple_write = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (kernel_dim == '0 || num_outputs == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                step         = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == WW'(READ_LATENCY - 1)) begin
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_state_next = (w_tap_inc == w_taps_total) ? S_WRITE : S_ISSUE;
            end
            S_WRITE: begin
                simple_write = 1'b1;
                w_state_next = (w_win_inc == r_num) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign en        = busy;
    assign read_mem1 = busy;
    assign read_mem2 = busy;

    // During the write cycle the fresh values go out directly. At all other times
    // the values of the last write are held.
    assign simple_write_addr = simple_write ? {NUM_UNITS{r_addr}} : r_wr_addr_hold;
    assign simple_write_data = simple_write ? w_sat_bus : r_wr_data_hold;

    // ---------------- Job parameters and counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k            <= '0;
            r_num          <= '0;
            r_win          <= '0;
            r_addr         <= '0;
            r_tap          <= '0;
            r_wait         <= '0;
            r_wr_addr_hold <= '0;
            r_wr_data_hold <= '0;
        end else begin
            if (w_start_go) begin
                r_k    <= kernel_dim;
                r_num  <= num_outputs;
                r_win  <= '0;
                r_addr <= w_base_mod;
                r_tap  <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_wait <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state == S_ACC) begin
                r_tap <= w_tap_inc;
            end
            if (r_state == S_WRITE) begin
                r_tap          <= '0;
                r_win          <= w_win_inc;
                r_addr         <= w_addr_inc;
                r_wr_addr_hold <= {NUM_UNITS{r_addr}};
                r_wr_data_hold <= w_sat_bus;
            end
        end
    end

    // ---------------- Per-lane MAC and saturation ----------------
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0]   w_a;
            logic signed [DATA_WIDTH-1:0]   w_b;
            logic signed [2*DATA_WIDTH-1:0] w_prod;
            logic signed [ACC_WIDTH-1:0]    w_prod_ext;
            logic signed [ACC_WIDTH-1:0]    r_acc;
            logic [DATA_WIDTH-1:0]          w_sat;

            assign w_a        = mem1_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_b        = mem2_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_prod     = w_a * w_b;
            assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_acc <= '0;
                end else if (w_start_go || r_state == S_WRITE) begin
                    r_acc <= '0;
                end else if (r_state == S_ACC) begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end

            always_comb begin
                w_sat = r_acc[DATA_WIDTH-1:0];
                if (r_acc > SAT_MAX) begin
                    w_sat = SAT_MAX[DATA_WIDTH-1:0];
                end else if (r_acc < SAT_MIN) begin
                    w_sat = SAT_MIN[DATA_WIDTH-1:0];
                end
            end

            assign w_sat_bus[gi*DATA_WIDTH +: DATA_WIDTH] = w_sat;
        end
    endgenerate

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer. dut0 uses a read latency of 1 and
// dut1 uses a read latency of 2. Each DUT gets a small window-reader model that
// produces tap data after the step pulse, delayed by the matching latency.

module tb_conv_mac_sequencer;

    logic        clk;
    logic        reset;
    logic        start_s [2];
    logic [1:0]  kernel_dim;
    logic [4:0]  num_outputs;
    logic [3:0]  out_addr_base;

    logic        en_s [2], rm1_s [2], rm2_s [2], step_s [2];
    logic        wr_s [2], busy_s [2], done_s [2];
    logic [7:0]  wa_s [2];
    logic [31:0] wd_s [2];
    logic [31:0] m1_s [2], m2_s [2];

    int tests = 0;
    int fails = 0;

    conv_mac_sequencer #(.READ_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]),
        .kernel_dim(kernel_dim), .num_outputs(num_outputs), .out_addr_base(out_addr_base),
        .en(en_s[0]), .read_mem1(rm1_s[0]), .read_mem2(rm2_s[0]), .step(step_s[0]),
        .mem1_data(m1_s[0]), .mem2_data(m2_s[0]),
        .simple_write(wr_s[0]), .simple_write_addr(wa_s[0]), .simple_write_data(wd_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    conv_mac_sequencer #(.READ_LATENCY(2)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]),
        .kernel_dim(kernel_dim), .num_outputs(num_outputs), .out_addr_base(out_addr_base),
        .en(en_s[1]), .read_mem1(rm1_s[1]), .read_mem2(rm2_s[1]), .step(step_s[1]),
        .mem1_data(m1_s[1]), .mem2_data(m2_s[1]),
        .simple_write(wr_s[1]), .simple_write_addr(wa_s[1]), .simple_write_data(wd_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- Window-reader model ----------------
    // mode 0: image {lane1=-2, lane0=3}, weight {5, 2}
    // mode 1: image {-32768, 32767}, weight {32767, 32767}
    // mode 2: image = tap index + 1 on both lanes, weight = 1
    int mode = 0;
    int tcnt [2];
    logic [31:0] p1a [2], p1b [2], p2a [2], p2b [2];

    function automatic logic [31:0] f_img(input int m, input int t);
        logic [15:0] v;
        v = 16'(t + 1);
        case (m)
            0:       return {16'hFFFE, 16'h0003};
            1:       return {16'h8000, 16'h7FFF};
            default: return {v, v};
        endcase
    endfunction

    function automatic logic [31:0] f_wgt(input int m);
        case (m)
            0:       return {16'h0005, 16'h0002};
            1:       return {16'h7FFF, 16'h7FFF};
            default: return {16'h0001, 16'h0001};
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (start_s[d] && !busy_s[d]) begin
                tcnt[d] <= 0;
            end else if (step_s[d]) begin
                tcnt[d] <= tcnt[d] + 1;
            end
            if (step_s[d]) begin
                p1a[d] <= f_img(mode, tcnt[d]);
                p1b[d] <= f_wgt(mode);
            end
            p2a[d] <= p1a[d];
            p2b[d] <= p1b[d];
        end
    end

    assign m1_s[0] = p1a[0];
    assign m2_s[0] = p1b[0];
    assign m1_s[1] = p2a[1];
    assign m2_s[1] = p2b[1];

    // ---------------- Output monitor (samples on falling edge) ----------------
    int epoch [2] = '{0, 0};
    int t0 [2] = '{0, 0};
    int last_epoch [2] = '{0, 0};
    int nstep [2], nwr [2], ndone [2], nbusy [2], done_cyc [2];
    int step_cyc [2][32];
    logic [7:0]  wr_addr [2][8];
    logic [31:0] wr_data [2][8];
    int mon_c;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (epoch[d] != last_epoch[d]) begin
                last_epoch[d] = epoch[d];
                nstep[d] = 0; nwr[d] = 0; ndone[d] = 0; nbusy[d] = 0; done_cyc[d] = -1;
            end
            mon_c = edge_cnt - t0[d];
            if (step_s[d]) begin
                if (nstep[d] < 32) step_cyc[d][nstep[d]] = mon_c;
                nstep[d]++;
            end
            if (wr_s[d]) begin
                if (nwr[d] < 8) begin
                    wr_addr[d][nwr[d]] = wa_s[d];
                    wr_data[d][nwr[d]] = wd_s[d];
                end
                nwr[d]++;
            end
            if (done_s[d]) begin
                ndone[d]++;
                done_cyc[d] = mon_c;
            end
            if (busy_s[d]) nbusy[d]++;
        end
    end

    // ---------------- Helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int d);
        @(posedge clk); #1;
        epoch[d]   = epoch[d] + 1;
        t0[d]      = edge_cnt;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int maxc);
        int k;
        k = 0;
        while (ndone[d] == 0 && k < maxc) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", 64'(ndone[d] != 0), 64'd1);
        repeat (4) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_cyc(input int d, input int c);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((edge_cnt - t0[d]) != c && k < 200);
        chk("cycle_reached", 64'(edge_cnt - t0[d]), 64'(c));
    endtask

    task automatic chk_steps(input int d, input int n, input int gap);
        chk("step_count", 64'(nstep[d]), 64'(n));
        chk("first_step_cycle", 64'(step_cyc[d][0]), 64'd1);
        for (int i = 0; i + 1 < n && i + 1 < nstep[d] && i < 31; i++) begin
            chk("step_spacing", 64'(step_cyc[d][i+1] - step_cyc[d][i]), 64'(gap));
        end
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        reset = 1'b1;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        kernel_dim = 2'd0; num_outputs = 5'd0; out_addr_base = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", 64'(busy_s[0]), 64'd0);
        chk("rst_en",   64'(en_s[0]),   64'd0);
        chk("rst_step", 64'(step_s[0]), 64'd0);
        chk("rst_wr",   64'(wr_s[0]),   64'd0);
        chk("rst_done", 64'(done_s[0]), 64'd0);
        chk("rst_addr", 64'(wa_s[0]),   64'd0);
        chk("rst_data", 64'(wd_s[0]),   64'd0);
        chk("rst_busy_rl2", 64'(busy_s[1]), 64'd0);
        reset = 1'b0;

        // 1: K=2, one window at base 5
        mode = 0; kernel_dim = 2'd2; num_outputs = 5'd1; out_addr_base = 4'd5;
        do_start(0);
        wait_done(0, 100);
        chk_steps(0, 4, 3);
        chk("t1_nwr", 64'(nwr[0]), 64'd1);
        chk("t1_addr", 64'(wr_addr[0][0]), 64'h55);
        chk("t1_data", 64'(wr_data[0][0]), 64'hFFD8_0018);
        chk("t1_done_cyc", 64'(done_cyc[0]), 64'd14);
        chk("t1_ndone", 64'(ndone[0]), 64'd1);
        chk("t1_hold_data", 64'(wd_s[0]), 64'hFFD8_0018);
        chk("t1_hold_addr", 64'(wa_s[0]), 64'h55);
        chk("t1_idle_busy", 64'(busy_s[0]), 64'd0);

        // 2: saturation, K=3
        mode = 1; kernel_dim = 2'd3; num_outputs = 5'd1; out_addr_base = 4'd0;
        do_start(0);
        wait_done(0, 200);
        chk("t2_nwr", 64'(nwr[0]), 64'd1);
        chk("t2_data", 64'(wr_data[0][0]), 64'h8000_7FFF);
        chk("t2_done_cyc", 64'(done_cyc[0]), 64'd29);

        // 3: three windows, address wrap, accumulator cleared between windows
        mode = 2; kernel_dim = 2'd2; num_outputs = 5'd3; out_addr_base = 4'd14;
        do_start(0);
        wait_done(0, 200);
        chk("t3_nstep", 64'(nstep[0]), 64'd12);
        chk("t3_nwr", 64'(nwr[0]), 64'd3);
        chk("t3_addr0", 64'(wr_addr[0][0]), 64'hEE);
        chk("t3_addr1", 64'(wr_addr[0][1]), 64'hFF);
        chk("t3_addr2", 64'(wr_addr[0][2]), 64'h00);
        chk("t3_data0", 64'(wr_data[0][0]), 64'h000A_000A);
        chk("t3_data1", 64'(wr_data[0][1]), 64'h001A_001A);
        chk("t3_data2", 64'(wr_data[0][2]), 64'h002A_002A);
        chk("t3_done_cyc", 64'(done_cyc[0]), 64'd40);

        // 4: kernel_dim = 0
        kernel_dim = 2'd0; num_outputs = 5'd2; out_addr_base = 4'd3;
        do_start(0);
        wait_done(0, 20);
        chk("t4_nstep", 64'(nstep[0]), 64'd0);
        chk("t4_nwr", 64'(nwr[0]), 64'd0);
        chk("t4_nbusy", 64'(nbusy[0]), 64'd1);
        chk("t4_done_cyc", 64'(done_cyc[0]), 64'd1);

        // 4b: num_outputs = 0
        kernel_dim = 2'd2; num_outputs = 5'd0;
        do_start(0);
        wait_done(0, 20);
        chk("t4b_nstep", 64'(nstep[0]), 64'd0);
        chk("t4b_done_cyc", 64'(done_cyc[0]), 64'd1);

        // 5: reset during WAIT of tap 2 (steps at 1,4,7 -> WAIT at 8)
        mode = 0; kernel_dim = 2'd2; num_outputs = 5'd1; out_addr_base = 4'd5;
        do_start(0);
        wait_cyc(0, 8);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("t5_step", 64'(step_s[0]), 64'd0);
        chk("t5_wr",   64'(wr_s[0]),   64'd0);
        chk("t5_busy", 64'(busy_s[0]), 64'd0);
        chk("t5_done", 64'(done_s[0]), 64'd0);
        chk("t5_no_partial_wr", 64'(nwr[0]), 64'd0);
        reset = 1'b0;
        do_start(0);
        wait_done(0, 100);
        chk("t5_nwr", 64'(nwr[0]), 64'd1);
        chk("t5_addr", 64'(wr_addr[0][0]), 64'h55);
        chk("t5_data", 64'(wr_data[0][0]), 64'hFFD8_0018);
        chk("t5_done_cyc", 64'(done_cyc[0]), 64'd14);

        // 6: read latency 2, extra start while busy with different inputs
        mode = 0; kernel_dim = 2'd2; num_outputs = 5'd1; out_addr_base = 4'd5;
        do_start(1);
        wait_cyc(1, 5);
        kernel_dim = 2'd3; num_outputs = 5'd4; out_addr_base = 4'd9;
        start_s[1] = 1'b1;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        wait_done(1, 100);
        repeat (10) begin
            @(negedge clk); #1;
        end
        chk_steps(1, 4, 4);
        chk("t6_nwr", 64'(nwr[1]), 64'd1);
        chk("t6_ndone", 64'(ndone[1]), 64'd1);
        chk("t6_addr", 64'(wr_addr[1][0]), 64'h55);
        chk("t6_data", 64'(wr_data[1][0]), 64'hFFD8_0018);
        chk("t6_done_cyc", 64'(done_cyc[1]), 64'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
Downstream compute/control stage for top_memory. Issues `step` pulses to walk the sliding-window read ports. Consumes image taps (mem1 side, out_1) and weight taps (mem2 side, out_2), and accumulates a signed dot product per unit over kernel_dim*kernel_dim taps. Writes each saturated window result into the simple memory through its write port. One sequencer drives all NUM_UNITS lanes in lockstep.

Parameters:
DATA_WIDTH, 16, tap/result width, signed two's complement
IMAGE_WIDTH, 4, image width; sizes kernel_dim
IMAGE_HEIGHT, 4, image height
NUM_UNITS, 2, parallel lanes
MEM_DEPTH, IMAGE_WIDTH*IMAGE_HEIGHT, memory depth; AW = $clog2(MEM_DEPTH)
ACC_WIDTH, 2*DATA_WIDTH+8, accumulator width
READ_LATENCY, 1, cycles from step high to valid mem data (>=1)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  single-cycle request; sampled in IDLE only
kernel_dim  in  $clog2(IMAGE_WIDTH)  kernel side K; taps per window = K*K
num_outputs  in  AW+1  windows to compute per lane
out_addr_base  in  AW  simple-memory address of window 0
en  out  1  memory enable
read_mem1  out  1  read enable to image memory
read_mem2  out  1  read enable to weight memory
step  out  1  one-cycle advance pulse to both window readers
mem1_data  in  NUM_UNITS*DATA_WIDTH  image taps (top_memory out_1)
mem2_data  in  NUM_UNITS*DATA_WIDTH  weight taps (top_memory out_2)
simple_write  out  1  one-cycle write strobe
simple_write_addr  out  NUM_UNITS*AW  per-lane address; all lanes equal
simple_write_data  out  NUM_UNITS*DATA_WIDTH  per-lane saturated result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0. FSM=IDLE. Accumulators, tap counter and window counter cleared. Reset overrides any state, including mid-window. No partial write is emitted.
- en, read_mem1 and read_mem2 equal busy.
- States: IDLE, ISSUE, WAIT, ACC, WRITE, DONE.
- IDLE: on start=1, latch kernel_dim, num_outputs and out_addr_base.
  - If kernel_dim==0 or num_outputs==0, go to DONE.
  - Otherwise go to ISSUE.
  - Later changes to the latched inputs have no effect until the next start.
- start while not in IDLE is ignored.
- ISSUE: step=1 for exactly this cycle, then go to WAIT.
- WAIT: stay READ_LATENCY cycles, counted from the ISSUE cycle, then go to ACC.
- ACC: for every lane, acc += signed(mem1_data[u]) * signed(mem2_data[u]). The product is sign-extended to ACC_WIDTH.
  - Tap counter increments.
  - If it reaches K*K, go to WRITE; otherwise go to ISSUE.
- Per-tap cost: 2+READ_LATENCY cycles.
- WRITE: simple_write=1 for one cycle.
  - Address = (out_addr_base + window_idx) mod MEM_DEPTH; wraps to 0.
  - Data = acc saturated to signed DATA_WIDTH: above 0x7FFF gives 0x7FFF, below -32768 gives 0x8000 (DATA_WIDTH=16).
  - Same cycle: accumulators and tap counter cleared, window_idx incremented.
  - If window_idx+1 == num_outputs, go to DONE; otherwise go to ISSUE.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- simple_write_addr and simple_write_data hold their last values outside WRITE. simple_write is 0 outside WRITE.
- Timing: start sampled at edge 0 gives the first step in cycle 1. One window takes K*K*(2+READ_LATENCY)+1 cycles. done asserts in the cycle after the final WRITE.
- Lanes are independent in arithmetic. Saturation is per lane.

Test Plan:
1. K=2, num_outputs=1, base=5, RL=1. Memory model holds mem1={3,-2}, mem2={2,5}. Required: exactly 4 step pulses, each 3 cycles apart; one simple_write with addr {5,5}, data {24,-40} (0x0018, 0xFFD8); done in cycle 14 after start.
2. Saturation: K=3, mem1=32767 and mem2=32767 on lane0; mem1=-32768 and mem2=32767 on lane1. Required: data {0x7FFF, 0x8000}.
3. num_outputs=3, base=14, K=2. Model returns mem1=tap index+1 (1..12 over the run), mem2=1. Required: writes at addresses 14, 15, 0 with data 10, 26, 42 (accumulator cleared between windows); 12 step pulses total.
4. kernel_dim=0 with start=1. Required: zero step pulses; no simple_write; busy for 1 cycle; done pulse in cycle 1.
5. Reset asserted during the WAIT of window 0, tap 2. Required: the following cycle has step, simple_write, busy and done all 0. A fresh start then reproduces the scenario 1 result exactly, with no residual accumulation.
6. RL=2 with a model that delays data by 2 cycles, plus a start pulse while busy. Required: correct result as in scenario 1; per-tap spacing of 4 cycles; the extra start is ignored (single done, single write).
